// File: rtl/serial_subtractor.sv
// Bit-serial A-B subtractor, LSB first, one bit per clock.
// Registered difference, final borrow and signed overflow.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             V,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bor_q, bor_d;
  logic             am_q, am_d;
  logic             bm_q, bm_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bout_q, bout_d;
  logic             v_q, v_d;

  logic             abit;
  logic             bbit;
  logic             dbit;
  logic             bnext;
  logic [WIDTH-1:0] rnext;

  // One full-subtractor cell on the current LSBs
  assign abit  = a_q[0];
  assign bbit  = b_q[0];
  assign dbit  = abit ^ bbit ^ bor_q;
  assign bnext = (~abit & bbit) | (~(abit ^ bbit) & bor_q);
  assign rnext = {dbit, res_q[WIDTH-1:1]};

  // Next-state logic: capture, shift, and publish on the last bit
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    bor_d   = bor_q;
    am_d    = am_q;
    bm_d    = bm_q;
    d_d     = d_q;
    bout_d  = bout_q;
    v_d     = v_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          am_d    = A[WIDTH-1];
          bm_d    = B[WIDTH-1];
          res_d   = '0;
          cnt_d   = '0;
          bor_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = rnext;
        bor_d = bnext;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          d_d     = rnext;
          bout_d  = bnext;
          v_d     = (am_q ^ bm_q) & (rnext[WIDTH-1] ^ am_q);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      bor_q   <= 1'b0;
      am_q    <= 1'b0;
      bm_q    <= 1'b0;
      d_q     <= '0;
      bout_q  <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      bor_q   <= bor_d;
      am_q    <= am_d;
      bm_q    <= bm_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
      v_q     <= v_d;
    end
  end

  assign D    = d_q;
  assign Bout = bout_q;
  assign V    = v_q;
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits (legal range 2..32).
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: start  input  1  request to begin one subtraction; sampled on rising clk.
REQ-005 Port: A  input  WIDTH  minuend; captured only on the edge that accepts start.
REQ-006 Port: B  input  WIDTH  subtrahend; captured only on the edge that accepts start.
REQ-007 Port: D  output  WIDTH  difference A-B mod 2^WIDTH (registered).
REQ-008 Port: Bout  output  1  final borrow; 1 iff A < B unsigned (registered).
REQ-009 Port: V  output  1  two's-complement overflow of A-B (registered).
REQ-010 Port: busy  output  1  high while bits are being processed.
REQ-011 Port: done  output  1  one-cycle pulse marking D/Bout/V newly valid.

Function
REQ-012 Three states SHALL exist: IDLE, RUN, DONE.
REQ-013 IDLE: on an edge with start=1, capture A and B into shift registers, clear the internal borrow bit and bit counter, and go to RUN.
REQ-014 IDLE with start=0 SHALL remain in IDLE; D/Bout/V unchanged.
REQ-015 RUN: each edge processes one operand bit, LSB first: d = a^b^bin; bnext = (~a&b) | (~(a^b)&bin).
REQ-016 RUN: each d SHALL be shifted into an internal result register from the MSB side, so that after WIDTH bits bit i holds difference bit i.
REQ-017 RUN SHALL last exactly WIDTH edges (counter 0..WIDTH-1), then go to DONE.
REQ-018 On the RUN->DONE edge, D SHALL load the full result, Bout the final borrow, and V = (A[MSB]!=B[MSB]) & (D[MSB]!=A[MSB]) using captured operands.
REQ-019 DONE lasts one cycle, then returns to IDLE unconditionally.
REQ-020 done SHALL be 1 only in DONE; busy SHALL be 1 only in RUN.
REQ-021 Latency: with start accepted at edge k, done SHALL be high during the cycle after edge k+WIDTH.
REQ-022 D, Bout, V SHALL hold their value from completion until the next completion; partial results SHALL never appear on D.
REQ-023 start in RUN or DONE SHALL be ignored; operand changes after acceptance SHALL not affect the result.
REQ-024 start held continuously high SHALL yield one accepted operation every WIDTH+2 cycles.

Reset
REQ-025 rst=1 at an edge SHALL force IDLE and set D=0, Bout=0, V=0, busy=0, done=0, counter and borrow to 0, regardless of state.
REQ-026 rst SHALL take priority over start on the same edge.
REQ-027 rst during RUN SHALL abort the operation with no done pulse; the next accepted start SHALL behave normally.

Verification (WIDTH=8)
REQ-028 A=100, B=58, start 1 cycle -> busy 8 cycles, done high 9 edges after acceptance, D=42, Bout=0, V=0.
REQ-029 A=5, B=10 -> D=8'hFB, Bout=1, V=0.
REQ-030 A=8'h80, B=8'h01 -> D=8'h7F, Bout=0, V=1; also A=8'h7F, B=8'hFF -> D=8'h80, Bout=1, V=1.
REQ-031 A=20, B=3 accepted, then start pulsed in RUN with A=1, B=2 -> done once, D=17; second request not executed.
REQ-032 rst asserted at 4th RUN cycle -> next cycle all outputs 0, no done; then A=8'hFF, B=8'hFF -> D=0, Bout=0, V=0.
REQ-033 start held high 30 cycles, A=0, B=1 -> done pulses spaced exactly 10 cycles, each with D=8'hFF, Bout=1, V=0.
